// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO reader: skid-buffer occupancy encoding and counter width.
// Optional feature macro: FIFO_READER_COUNT_EN (adds the words_out handshake counter).
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_reader_reg.sv
// WIDTH-bit data register with synchronous active-high reset and load enable.
module fifo_reader_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Consumer for the 4-entry FIFO: pops head words into a 2-entry skid buffer and streams them out.
// Optional feature macro: FIFO_READER_COUNT_EN adds the 16-bit words_out deq counter port.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             pop_fifo,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [CNT_W-1:0] words_out
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic             deq;
  logic             h_en;
  logic             t_en;
  logic [WIDTH-1:0] h_d;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] t_q;

  // Pop is decided from registered state and FIFO/control inputs only, so
  // out_ready never reaches pop_fifo combinationally.
  assign pop_fifo  = ~rst & ~flush & ~fifo_empty & (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign deq       = out_valid & out_ready;
  assign out_data  = h_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_en      = 1'b0;
    t_en      = 1'b0;
    h_d       = fifo_rd_data;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_ONE: begin
          if (pop_fifo && deq) begin
            h_en = 1'b1;
          end else if (pop_fifo) begin
            state_nxt = ST_TWO;
            t_en      = 1'b1;
          end else if (deq) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (deq) begin
            state_nxt = ST_ONE;
            h_en      = 1'b1;
            h_d       = t_q;
          end
        end
        // ST_EMPTY, and any corrupted encoding recovers through the empty path
        default: begin
          state_nxt = ST_EMPTY;
          if (pop_fifo) begin
            state_nxt = ST_ONE;
            h_en      = 1'b1;
          end
        end
      endcase
    end
  end

  fifo_reader_reg #(.WIDTH(WIDTH)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (h_en),
    .d   (h_d),
    .q   (h_q)
  );

  fifo_reader_reg #(.WIDTH(WIDTH)) u_tail (
    .clk (clk),
    .rst (rst),
    .en  (t_en),
    .d   (fifo_rd_data),
    .q   (t_q)
  );

`ifdef FIFO_READER_COUNT_EN
  // Counts completed handshakes; only rst clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_out <= '0;
    end else if (deq) begin
      words_out <= words_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a small behavioural model of the FIFO head.
module tb_fifo_reader;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             pop_fifo;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0]      words_out;
`endif

  logic [WIDTH-1:0] mem [16];
  int               rd_idx = 0;
  int               wr_idx = 0;
  int               n_checks = 0;
  int               n_fails = 0;
  int               mark;

  always #5 clk = ~clk;

  assign fifo_empty   = (rd_idx == wr_idx);
  assign fifo_rd_data = mem[rd_idx[3:0]];

  always @(posedge clk) begin
    if (pop_fifo) rd_idx <= rd_idx + 1;
  end

  fifo_reader #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .pop_fifo     (pop_fifo),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
`ifdef FIFO_READER_COUNT_EN
    ,
    .words_out    (words_out)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_idx[3:0]] = d;
    wr_idx = wr_idx + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    push(16'hBEEF);

    // Reset with a non-empty FIFO: nothing may pop
    step();
    chk("rst1_pop", pop_fifo, 0);
    chk("rst1_valid", out_valid, 0);
    chk("rst1_data", out_data, 0);
    step();
    chk("rst2_pop", pop_fifo, 0);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("first_pop", pop_fifo, 1);
    step();
    chk("beef_valid", out_valid, 1);
    chk("beef_data", out_data, 16'hBEEF);
    chk("beef_nopop", pop_fifo, 0);
    out_ready = 1'b1;
    step();
    chk("beef_drained", out_valid, 0);

    // Streaming at one word per cycle
    push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
    #1;
    chk("stream_pop", pop_fifo, 1);
    step(); chk("stream_d1", out_data, 16'h0001); chk("stream_v1", out_valid, 1);
    step(); chk("stream_d2", out_data, 16'h0002);
    step(); chk("stream_d3", out_data, 16'h0003);
    step(); chk("stream_d4", out_data, 16'h0004);
    chk("stream_pop_empty", pop_fifo, 0);
    step(); chk("stream_done", out_valid, 0);

    // Back-pressure: two pops fill the buffer, then the head holds
    out_ready = 1'b0;
    mark = rd_idx;
    push(16'h00A1); push(16'h00A2); push(16'h00A3);
    step(); chk("bp_d1", out_data, 16'h00A1);
    step(); chk("bp_full_pop", pop_fifo, 0);
    chk("bp_hold_d", out_data, 16'h00A1);
    step(); chk("bp_hold_d2", out_data, 16'h00A1);
    chk("bp_hold_v", out_valid, 1);
    chk("bp_pops", rd_idx - mark, 2);
    out_ready = 1'b1;
    step(); chk("bp_d2", out_data, 16'h00A2);
    step(); chk("bp_d3", out_data, 16'h00A3);
    step(); chk("bp_done", out_valid, 0);
    chk("bp_total_pops", rd_idx - mark, 3);

    // Flush from a full buffer leaves the FIFO head unpopped
    out_ready = 1'b0;
    push(16'h00B1); push(16'h00B2); push(16'h00B3);
    step(); step();
    mark = rd_idx;
    flush = 1'b1;
    #1;
    chk("flush_pop", pop_fifo, 0);
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_head", rd_idx - mark, 0);
    out_ready = 1'b1;
    step(); chk("flush_resume", out_data, 16'h00B3);
    step(); chk("flush_drained", out_valid, 0);

    // Flush while empty must block a pending pop
    push(16'h00C1);
    flush = 1'b1;
    #1;
    chk("flush_empty_pop", pop_fifo, 0);
    step();
    chk("flush_empty_valid", out_valid, 0);
    flush = 1'b0;
    step(); chk("flush_empty_resume", out_data, 16'h00C1);
    step();

    // Reset mid-stream while holding one word
    out_ready = 1'b0;
    push(16'h00D1);
    step(); chk("mrst_d1", out_data, 16'h00D1);
    push(16'h00D2);
    rst = 1'b1;
    #1;
    chk("mrst_pop", pop_fifo, 0);
    step();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_pop2", pop_fifo, 0);
    rst = 1'b0;
    step(); chk("mrst_resume", out_data, 16'h00D2);
    out_ready = 1'b1;
    step(); chk("mrst_drained", out_valid, 0);

`ifdef FIFO_READER_COUNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cnt_reset", words_out, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (wr_idx - rd_idx < 4) push(i[15:0]);
      step();
      if (words_out == 16'hFFFF) break;
    end
    out_ready = 1'b0;
    push(16'h1111); push(16'h2222);
    step(); step();
    chk("cnt_max", words_out, 16'hFFFF);
    out_ready = 1'b1;
    step(); chk("cnt_wrap", words_out, 16'h0000);
    step(); chk("cnt_one", words_out, 16'h0001);
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); chk("cnt_flush", words_out, 16'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
